// File: rtl/maclaurin_eval_if.sv
// Operand/result handshake bundle for the Maclaurin sin/cos evaluator.
// The master side is the operand source and result consumer; the slave side is the evaluator.
interface maclaurin_eval_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic             func;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             busy;

  modport master (
    output in_valid, x, func, out_ready,
    input  in_ready, out_valid, y, busy
  );

  modport slave (
    input  in_valid, x, func, out_ready,
    output in_ready, out_valid, y, busy
  );
endinterface

// File: rtl/maclaurin_eval.sv
// Sequential sin/cos evaluator on Q0.WIDTH operands using Horner's method and one
// shared WIDTH x WIDTH multiplier, one polynomial step per clock.
module maclaurin_eval #(
  parameter int WIDTH = 16,
  parameter int TERMS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  maclaurin_eval_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SQ, HORNER, MULX, DONE} state_t;

  localparam logic [WIDTH-1:0] MAXV = '1;

  // c(n) = round(2^WIDTH / n!), with 1.0 saturated to all ones; entries past TERMS stay zero
  function automatic logic [7:0][WIDTH-1:0] genCoef(input int offset);
    logic [7:0][WIDTH-1:0] tbl;
    longint fact;
    longint v;
    tbl = '0;
    for (int k = 0; k < TERMS; k++) begin
      fact = 1;
      for (int i = 2; i <= 2 * k + offset; i++) fact = fact * longint'(i);
      v = ((longint'(1) << WIDTH) + fact / 2) / fact;
      tbl[k] = (v > longint'(MAXV)) ? MAXV : v[WIDTH-1:0];
    end
    return tbl;
  endfunction

  localparam logic [7:0][WIDTH-1:0] CS = genCoef(1);
  localparam logic [7:0][WIDTH-1:0] CC = genCoef(0);
  localparam logic [2:0] K_START = (TERMS > 1) ? 3'(TERMS - 2) : 3'd0;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0]   r_x;
  logic               r_func;
  logic [WIDTH-1:0]   r_x2;
  logic [WIDTH-1:0]   r_acc;
  logic [2:0]         r_k;
  logic [WIDTH-1:0]   r_y;

  logic [WIDTH-1:0]   w_mulA;
  logic [WIDTH-1:0]   w_mulB;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_trunc;
  logic [WIDTH-1:0]   w_coef;
  logic [WIDTH-1:0]   w_lastCoef;
  logic [WIDTH-1:0]   w_diff;
  logic [WIDTH-1:0]   w_accNext;
  logic               w_inReady;
  logic               w_outValid;
  logic               w_busy;

  // Single multiplier shared by the x^2, Horner and final-x steps
  always_comb begin
    w_mulA = r_x;
    w_mulB = r_x;
    case (r_state)
      HORNER: begin
        w_mulA = r_x2;
        w_mulB = r_acc;
      end
      MULX: begin
        w_mulA = r_acc;
        w_mulB = r_x;
      end
      default: ;
    endcase
  end

  assign w_prod     = (2*WIDTH)'(w_mulA) * (2*WIDTH)'(w_mulB);
  assign w_trunc    = WIDTH'(w_prod >> WIDTH);
  assign w_coef     = r_func ? CC[r_k] : CS[r_k];
  assign w_lastCoef = r_func ? CC[TERMS-1] : CS[TERMS-1];
  assign w_diff     = (w_trunc > w_coef) ? '0 : (w_coef - w_trunc);

  always_comb begin
    w_accNext = r_acc;
    case (r_state)
      SQ:      w_accNext = w_lastCoef;
      HORNER:  w_accNext = w_diff;
      MULX:    w_accNext = w_trunc;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   if (bus.in_valid) w_next = SQ;
      SQ: begin
        if (TERMS > 1)   w_next = HORNER;
        else if (r_func) w_next = DONE;
        else             w_next = MULX;
      end
      HORNER: if (r_k == 3'd0) w_next = r_func ? DONE : MULX;
      MULX:   w_next = DONE;
      DONE:   if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_inReady  = (r_state == IDLE);
    w_outValid = (r_state == DONE);
    w_busy     = (r_state != IDLE);
  end

  // y is captured only on entry to DONE so it holds steady outside of DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x    <= '0;
      r_func <= 1'b0;
      r_x2   <= '0;
      r_acc  <= '0;
      r_k    <= '0;
      r_y    <= '0;
    end else begin
      if (r_state == IDLE && bus.in_valid) begin
        r_x    <= bus.x;
        r_func <= bus.func;
      end
      if (r_state == SQ) begin
        r_x2 <= w_trunc;
        r_k  <= K_START;
      end
      if (r_state == HORNER) r_k <= r_k - 3'd1;
      r_acc <= w_accNext;
      if (w_next == DONE && r_state != DONE) r_y <= w_accNext;
    end
  end

  assign bus.in_ready  = w_inReady;
  assign bus.out_valid = w_outValid;
  assign bus.busy      = w_busy;
  assign bus.y         = r_y;

endmodule

// File: tb/tb_maclaurin_eval.sv
// Self-checking bench for maclaurin_eval: three instances (16/4, 16/1, 12/8) sharing one
// clock and reset, with a scoreboard queue of expected results.
module tb_maclaurin_eval;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        drvValid = 1'b0;
  logic        drvFunc = 1'b0;
  logic        drvReady = 1'b0;
  logic [15:0] drvX = 16'h0;
  int          sel = 0;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] expQ[$];

  logic        obsInReady;
  logic        obsValid;
  logic        obsBusy;
  logic [15:0] obsY;

  always #5 clk = ~clk;

  maclaurin_eval_if #(.WIDTH(16)) bus0 ();
  maclaurin_eval_if #(.WIDTH(16)) bus1 ();
  maclaurin_eval_if #(.WIDTH(12)) bus2 ();

  assign bus0.in_valid  = drvValid && (sel == 0);
  assign bus0.x         = drvX;
  assign bus0.func      = drvFunc;
  assign bus0.out_ready = drvReady;
  assign bus1.in_valid  = drvValid && (sel == 1);
  assign bus1.x         = drvX;
  assign bus1.func      = drvFunc;
  assign bus1.out_ready = drvReady;
  assign bus2.in_valid  = drvValid && (sel == 2);
  assign bus2.x         = drvX[11:0];
  assign bus2.func      = drvFunc;
  assign bus2.out_ready = drvReady;

  maclaurin_eval #(.WIDTH(16), .TERMS(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  maclaurin_eval #(.WIDTH(16), .TERMS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  maclaurin_eval #(.WIDTH(12), .TERMS(8)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  // Route the selected instance's outputs to one set of observation signals
  always_comb begin
    case (sel)
      1: begin
        obsInReady = bus1.in_ready; obsValid = bus1.out_valid;
        obsBusy    = bus1.busy;     obsY     = bus1.y;
      end
      2: begin
        obsInReady = bus2.in_ready; obsValid = bus2.out_valid;
        obsBusy    = bus2.busy;     obsY     = {4'h0, bus2.y};
      end
      default: begin
        obsInReady = bus0.in_ready; obsValid = bus0.out_valid;
        obsBusy    = bus0.busy;     obsY     = bus0.y;
      end
    endcase
  end

  function automatic longint coefM(input int n, input int w);
    longint f;
    longint v;
    f = 1;
    for (int i = 2; i <= n; i++) f = f * longint'(i);
    v = ((longint'(1) << w) + f / 2) / f;
    if (v > (longint'(1) << w) - 1) v = (longint'(1) << w) - 1;
    return v;
  endfunction

  function automatic logic [15:0] model(input longint xv, input bit f, input int w, input int t);
    longint x2, acc, p, c;
    int off;
    off = f ? 0 : 1;
    x2  = (xv * xv) >> w;
    acc = coefM(2 * (t - 1) + off, w);
    for (int k = t - 2; k >= 0; k--) begin
      p   = (x2 * acc) >> w;
      c   = coefM(2 * k + off, w);
      acc = (p > c) ? 0 : c - p;
    end
    if (!f) acc = (acc * xv) >> w;
    return acc[15:0];
  endfunction

  function automatic int expLatency(input int s, input bit f);
    int t;
    t = (s == 0) ? 4 : (s == 1) ? 1 : 8;
    return f ? t : t + 1;
  endfunction

  // Drives one operand and waits (bounded) for out_valid; comparisons stay with the caller
  task automatic runOp(input int s, input logic [15:0] xv, input logic f,
                       output bit ok, output int edges);
    int n;
    n = 0;
    edges = 0;
    sel = s;
    drvX = xv;
    drvFunc = f;
    @(negedge clk);
    while (!obsInReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!obsInReady) begin
      ok = 1'b0;
      return;
    end
    drvValid = 1'b1;
    @(posedge clk);
    #1 drvValid = 1'b0;
    do begin
      @(posedge clk);
      edges++;
      #1;
    end while (!obsValid && edges < 60);
    ok = obsValid;
  endtask

  task automatic releaseResult();
    drvReady = 1'b1;
    @(posedge clk);
    #1 drvReady = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sel = 0;
    #2;
    checks++;
    if (obsInReady !== 1'b1 || obsValid !== 1'b0 || obsY !== 16'h0 || obsBusy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_values: in_ready=%b out_valid=%b y=%h busy=%b, want 1 0 0000 0",
               obsInReady, obsValid, obsY, obsBusy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      checks++;
      if (obsInReady !== 1'b1 || obsValid !== 1'b0 || obsY !== 16'h0 || obsBusy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL idle_after_reset dut%0d: in_ready=%b out_valid=%b y=%h busy=%b, want 1 0 0000 0",
                 s, obsInReady, obsValid, obsY, obsBusy);
      end
    end
  endtask

  task automatic test_sin_cos();
    logic [15:0] tx [4] = '{16'h8000, 16'h8000, 16'h0000, 16'h0000};
    logic        tf [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] te [4] = '{16'h7ABB, 16'hE0A9, 16'h0000, 16'hFFFF};
    bit ok;
    int edges;
    logic [15:0] e;
    for (int i = 0; i < 4; i++) begin
      expQ.push_back(te[i]);
      runOp(0, tx[i], tf[i], ok, edges);
      e = expQ.pop_front();
      checks++;
      if (!ok) begin
        errors++;
        $display("[TB] FAIL sincos%0d_timeout: out_valid=%b, want 1", i, obsValid);
      end else begin
        checks++;
        if (obsY !== e) begin
          errors++;
          $display("[TB] FAIL sincos%0d_y: got %h, want %h", i, obsY, e);
        end
        checks++;
        if (edges != expLatency(0, tf[i])) begin
          errors++;
          $display("[TB] FAIL sincos%0d_latency: got %0d, want %0d", i, edges, expLatency(0, tf[i]));
        end
        checks++;
        if (obsBusy !== 1'b1 || obsInReady !== 1'b0) begin
          errors++;
          $display("[TB] FAIL sincos%0d_done_flags: busy=%b in_ready=%b, want 1 0", i, obsBusy, obsInReady);
        end
      end
      releaseResult();
      checks++;
      if (obsInReady !== 1'b1 || obsValid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL sincos%0d_return_idle: in_ready=%b out_valid=%b, want 1 0", i, obsInReady, obsValid);
      end
    end
  endtask

  task automatic test_back_pressure();
    bit ok;
    int edges;
    logic [15:0] e;
    expQ.push_back(16'h7ABB);
    runOp(0, 16'h8000, 1'b0, ok, edges);
    e = expQ.pop_front();
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL bp_timeout: out_valid=%b, want 1", obsValid);
    end
    for (int c = 0; c < 10; c++) begin
      drvX = 16'($urandom);
      drvFunc = ~drvFunc;
      @(posedge clk);
      #1;
      checks++;
      if (obsValid !== 1'b1 || obsY !== e || obsInReady !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_hold%0d: out_valid=%b y=%h in_ready=%b, want 1 %h 0",
                 c, obsValid, obsY, obsInReady, e);
      end
    end
    releaseResult();
    checks++;
    if (obsInReady !== 1'b1 || obsValid !== 1'b0 || obsY !== e) begin
      errors++;
      $display("[TB] FAIL bp_release: in_ready=%b out_valid=%b y=%h, want 1 0 %h", obsInReady, obsValid, obsY, e);
    end
    expQ.push_back(model(64'h4000, 1'b1, 16, 4));
    runOp(0, 16'h4000, 1'b1, ok, edges);
    e = expQ.pop_front();
    checks++;
    if (!ok || obsY !== e) begin
      errors++;
      $display("[TB] FAIL bp_next_op: valid=%b y=%h, want 1 %h", ok, obsY, e);
    end
    releaseResult();
  endtask

  task automatic test_reset_midop();
    bit ok;
    int edges;
    bit seen;
    logic [15:0] e;
    sel = 0;
    drvX = 16'h8000;
    drvFunc = 1'b0;
    @(negedge clk);
    expQ.push_back(16'h7ABB);
    drvValid = 1'b1;
    @(posedge clk);
    #1 drvValid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obsBusy !== 1'b1 || obsValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midop_busy: busy=%b out_valid=%b, want 1 0", obsBusy, obsValid);
    end
    rst_n = 1'b0;
    expQ.delete();
    #1;
    checks++;
    if (obsInReady !== 1'b1 || obsValid !== 1'b0 || obsY !== 16'h0 || obsBusy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midop_reset: in_ready=%b out_valid=%b y=%h busy=%b, want 1 0 0000 0",
               obsInReady, obsValid, obsY, obsBusy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (obsValid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("[TB] FAIL midop_stale: out_valid seen=1, want 0");
    end
    expQ.push_back(16'h7ABB);
    runOp(0, 16'h8000, 1'b0, ok, edges);
    e = expQ.pop_front();
    checks++;
    if (!ok || obsY !== e || edges != 5) begin
      errors++;
      $display("[TB] FAIL midop_after: valid=%b y=%h edges=%0d, want 1 %h 5", ok, obsY, edges, e);
    end
    releaseResult();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int edges;
    logic [15:0] xv;
    logic        f;
    logic [15:0] e;
    for (int i = 0; i < 6; i++) begin
      xv = 16'($urandom_range(0, 65535));
      f  = 1'($urandom_range(0, 1));
      expQ.push_back(model(longint'(xv), f, 16, 4));
      runOp(0, xv, f, ok, edges);
      e = expQ.pop_front();
      checks++;
      if (!ok || obsY !== e || edges != expLatency(0, f)) begin
        errors++;
        $display("[TB] FAIL b2b%0d x=%h f=%b: valid=%b y=%h edges=%0d, want 1 %h %0d",
                 i, xv, f, ok, obsY, edges, e, expLatency(0, f));
      end
      releaseResult();
    end
  endtask

  task automatic test_terms1();
    logic [15:0] tx [4] = '{16'h8000, 16'h8000, 16'h1234, 16'h0003};
    logic        tf [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [15:0] te [4] = '{16'h7FFF, 16'hFFFF, 16'hFFFF, 16'h0002};
    bit ok;
    int edges;
    logic [15:0] e;
    for (int i = 0; i < 4; i++) begin
      expQ.push_back(te[i]);
      runOp(1, tx[i], tf[i], ok, edges);
      e = expQ.pop_front();
      checks++;
      if (!ok || obsY !== e || edges != expLatency(1, tf[i])) begin
        errors++;
        $display("[TB] FAIL terms1_%0d: valid=%b y=%h edges=%0d, want 1 %h %0d",
                 i, ok, obsY, edges, e, expLatency(1, tf[i]));
      end
      releaseResult();
    end
  endtask

  task automatic test_w12();
    logic [15:0] tx [5] = '{16'h000, 16'h800, 16'hFFF, 16'h555, 16'hABC};
    bit ok;
    int edges;
    int diff;
    logic [15:0] e;
    for (int i = 0; i < 5; i++) begin
      for (int f = 0; f < 2; f++) begin
        expQ.push_back(model(longint'(tx[i]), f[0], 12, 8));
        runOp(2, tx[i], f[0], ok, edges);
        e = expQ.pop_front();
        diff = int'(obsY) - int'(e);
        if (diff < 0) diff = -diff;
        checks++;
        if (!ok || diff > 2 || edges != expLatency(2, f[0])) begin
          errors++;
          $display("[TB] FAIL w12 x=%h f=%0d: valid=%b y=%h edges=%0d, want 1 %h(+-2) %0d",
                   tx[i], f, ok, obsY, edges, e, expLatency(2, f[0]));
        end
        releaseResult();
      end
    end
  endtask

  initial begin
    test_reset();
    test_sin_cos();
    test_back_pressure();
    test_reset_midop();
    test_back_to_back();
    test_terms1();
    test_w12();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
